// File: rtl/btb_update_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// btb_update_scheduler_pkg
// Shared types for the BTB update scheduler: branch-type encodings, the queued
// update record and the scheduler state enum.
// Optional feature macro used by the design: BTB_UPD_COALESCE_EN
// ---------------------------------------------------------------------------
package btb_update_scheduler_pkg;

    localparam logic [1:0] DIRECT   = 2'b00;
    localparam logic [1:0] CALL     = 2'b01;
    localparam logic [1:0] RETURN   = 2'b10;
    localparam logic [1:0] INDIRECT = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] bta;
        logic [1:0]  br_type;
    } btb_upd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } sched_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// ---------------------------------------------------------------------------
// btb_upd_fifo
// Dual-enqueue, single-dequeue circular FIFO of btb_upd_t records.
// Slot 0 is written before slot 1 in the same cycle. flush_i empties the
// queue and takes priority over anything enqueued in the same cycle.
//
// Build option (macro BTB_UPD_COALESCE_EN): a request whose pc matches a live
// entry overwrites that entry's payload instead of allocating. The head being
// popped this cycle never matches. Equal pcs on both slots collapse into one
// entry carrying slot 1's payload.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   flush_i               discard all entries
//   enq0_valid_i/data_i   enqueue slot 0 (older)
//   enq1_valid_i/data_i   enqueue slot 1 (younger)
//   deq_i                 pop the head
//   head_o                head entry (valid while count_o != 0)
//   count_o               occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module btb_upd_fifo
    import btb_update_scheduler_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             enq0_valid_i,
    input  btb_upd_t         enq0_data_i,
    input  logic             enq1_valid_i,
    input  btb_upd_t         enq1_data_i,
    input  logic             deq_i,
    output btb_upd_t         head_o,
    output logic [CNT_W-1:0] count_o
);

    btb_upd_t         mem_q [DEPTH];
    btb_upd_t         mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             alloc0, alloc1;
    logic             hit0, hit1, same_pc;
    logic [PTR_W-1:0] hit0_idx, hit1_idx;
    logic [PTR_W-1:0] wr0_idx, wr1_idx;

`ifdef BTB_UPD_COALESCE_EN
    // An entry is a match candidate if it lies between head and tail and is
    // not the head leaving this cycle.
    logic [DEPTH-1:0] live;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = ({1'b0, PTR_W'(i) - head_q} < count_q) &&
                      !(deq_i && (PTR_W'(i) == head_q));
        end
    end
`endif

    always_comb begin
        hit0     = 1'b0;
        hit1     = 1'b0;
        hit0_idx = '0;
        hit1_idx = '0;
        same_pc  = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (mem_q[i].pc == enq0_data_i.pc)) begin
                hit0     = 1'b1;
                hit0_idx = PTR_W'(i);
            end
            if (live[i] && (mem_q[i].pc == enq1_data_i.pc)) begin
                hit1     = 1'b1;
                hit1_idx = PTR_W'(i);
            end
        end
        same_pc = enq0_valid_i && (enq0_data_i.pc == enq1_data_i.pc);
`endif
        alloc0 = enq0_valid_i && !hit0;
        alloc1 = enq1_valid_i && !hit1 && !same_pc;

        wr0_idx = hit0 ? hit0_idx : tail_q;
        if (hit1) begin
            wr1_idx = hit1_idx;
        end else if (same_pc) begin
            // slot 1 lands on slot 0's freshly allocated entry and wins
            wr1_idx = wr0_idx;
        end else begin
            wr1_idx = tail_q + PTR_W'(alloc0);
        end

        mem_d = mem_q;
        if (enq0_valid_i) mem_d[wr0_idx] = enq0_data_i;
        if (enq1_valid_i) mem_d[wr1_idx] = enq1_data_i;

        head_d  = head_q + PTR_W'(deq_i);
        tail_d  = tail_q + PTR_W'(alloc0) + PTR_W'(alloc1);
        count_d = count_q + CNT_W'(alloc0) + CNT_W'(alloc1) - CNT_W'(deq_i);

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // payload storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/btb_update_scheduler.sv
// ---------------------------------------------------------------------------
// btb_update_scheduler
// Serialises branch-resolution updates from two commit slots onto the BTB's
// single update port through a small in-order queue, and runs the BTB
// invalidate sweep (one set per cycle) on flush_req.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | accept requests per count rule, drain one update per cycle
//   FLUSH | queue discarded, clear_en sweeps clear_idx 0..SETS-1
//
// Build option: BTB_UPD_COALESCE_EN merges requests to a pc already queued.
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   in0_* / in1_*                     commit-slot requests (slot 0 older)
//   in0_ready / in1_ready             accept, from registered state only
//   update_en/pc/BTA/type             registered BTB write port
//   flush_req                         pulse: start (or restart) the sweep
//   clear_en, clear_idx, flush_busy   registered sweep outputs
// ---------------------------------------------------------------------------
module btb_update_scheduler
    import btb_update_scheduler_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int SETS  = 32,
    parameter  int IDX_W = 5,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    input  logic [31:0]      in0_pc,
    input  logic [31:0]      in0_bta,
    input  logic [1:0]       in0_type,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [31:0]      in1_pc,
    input  logic [31:0]      in1_bta,
    input  logic [1:0]       in1_type,
    output logic             in1_ready,
    output logic             update_en,
    output logic [31:0]      update_pc,
    output logic [31:0]      update_BTA,
    output logic [1:0]       update_type,
    input  logic             flush_req,
    output logic             clear_en,
    output logic [IDX_W-1:0] clear_idx,
    output logic             flush_busy
);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] clear_idx_q, clear_idx_d;
    logic             upd_en_q;
    btb_upd_t         upd_q;

    btb_upd_t         slot0, slot1, fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             enq0, enq1, deq;

    assign in0_ready = (state_q == IDLE) && (fifo_count <= CNT_W'(DEPTH - 1));
    assign in1_ready = (state_q == IDLE) && (fifo_count <= CNT_W'(DEPTH - 2));

    assign enq0 = in0_valid && in0_ready;
    assign enq1 = in1_valid && in1_ready;

    // A flush request in IDLE suppresses the pop so nothing leaks onto the
    // update port once the sweep has begun.
    assign deq = (state_q == IDLE) && (fifo_count != '0) && !flush_req;

    assign slot0 = '{pc: in0_pc, bta: in0_bta, br_type: in0_type};
    assign slot1 = '{pc: in1_pc, bta: in1_bta, br_type: in1_type};

    btb_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .reset_i      (reset),
        .flush_i      (flush_req),
        .enq0_valid_i (enq0),
        .enq0_data_i  (slot0),
        .enq1_valid_i (enq1),
        .enq1_data_i  (slot1),
        .deq_i        (deq),
        .head_o       (fifo_head),
        .count_o      (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d     = FLUSH;
                    clear_idx_d = '0;
                end
            end
            FLUSH: begin
                if (flush_req) begin
                    clear_idx_d = '0;
                end else if (clear_idx_q == IDX_W'(SETS - 1)) begin
                    state_d     = IDLE;
                    clear_idx_d = '0;
                end else begin
                    clear_idx_d = clear_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                clear_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            clear_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_en_q <= 1'b0;
            upd_q    <= '0;
        end else begin
            upd_en_q <= deq;
            if (deq) begin
                upd_q <= fifo_head;
            end
        end
    end

    assign update_en   = upd_en_q;
    assign update_pc   = upd_q.pc;
    assign update_BTA  = upd_q.bta;
    assign update_type = upd_q.br_type;

    assign clear_en   = (state_q == FLUSH);
    assign flush_busy = (state_q == FLUSH);
    assign clear_idx  = clear_idx_q;

endmodule

// File: tb/tb_btb_update_scheduler.sv
module tb_btb_update_scheduler;
    import btb_update_scheduler_pkg::*;

    localparam int DEPTH = 4;
    localparam int SETS  = 32;
    localparam int IDX_W = 5;

    logic             clk;
    logic             reset;
    logic             in0_valid, in1_valid;
    logic [31:0]      in0_pc, in1_pc, in0_bta, in1_bta;
    logic [1:0]       in0_type, in1_type;
    logic             in0_ready, in1_ready;
    logic             update_en;
    logic [31:0]      update_pc, update_BTA;
    logic [1:0]       update_type;
    logic             flush_req;
    logic             clear_en;
    logic [IDX_W-1:0] clear_idx;
    logic             flush_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got_pc [$];
    logic [31:0] got_bta [$];

    btb_update_scheduler #(
        .DEPTH (DEPTH),
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in0_valid   (in0_valid),
        .in0_pc      (in0_pc),
        .in0_bta     (in0_bta),
        .in0_type    (in0_type),
        .in0_ready   (in0_ready),
        .in1_valid   (in1_valid),
        .in1_pc      (in1_pc),
        .in1_bta     (in1_bta),
        .in1_type    (in1_type),
        .in1_ready   (in1_ready),
        .update_en   (update_en),
        .update_pc   (update_pc),
        .update_BTA  (update_BTA),
        .update_type (update_type),
        .flush_req   (flush_req),
        .clear_en    (clear_en),
        .clear_idx   (clear_idx),
        .flush_busy  (flush_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one cycle, sample 1 time unit after the edge, log BTB writes
    task automatic tick();
        @(posedge clk);
        #1;
        if (update_en) begin
            got_pc.push_back(update_pc);
            got_bta.push_back(update_BTA);
        end
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0; in0_pc = '0; in0_bta = '0; in0_type = DIRECT;
        in1_valid = 1'b0; in1_pc = '0; in1_bta = '0; in1_type = DIRECT;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          next_id;
        int          n_clr;
        logic        restarted;
        logic [3:0]  r1_tab;

        reset     = 1'b1;
        flush_req = 1'b0;
        idle_inputs();
        tick();
        tick();

        // reset values
        chk("rst_update_en",   update_en,   0);
        chk("rst_update_pc",   update_pc,   0);
        chk("rst_update_bta",  update_BTA,  0);
        chk("rst_update_type", update_type, 0);
        chk("rst_clear_en",    clear_en,    0);
        chk("rst_clear_idx",   clear_idx,   0);
        chk("rst_flush_busy",  flush_busy,  0);
        reset = 1'b0;
        chk("rst_ready0", in0_ready, 1);
        chk("rst_ready1", in1_ready, 1);

        // single request: queued at one edge, written out after the next
        got_pc.delete(); got_bta.delete();
        in0_valid = 1'b1; in0_pc = 32'h1000; in0_bta = 32'h2000; in0_type = DIRECT;
        tick();
        idle_inputs();
        chk("t1_no_bypass", update_en, 0);
        chk("t1_count1",    dut.fifo_count, 1);
        tick();
        chk("t1_update_en",   update_en,   1);
        chk("t1_update_pc",   update_pc,   32'h1000);
        chk("t1_update_bta",  update_BTA,  32'h2000);
        chk("t1_update_type", update_type, DIRECT);
        chk("t1_count0",      dut.fifo_count, 0);
        tick();
        chk("t1_single", update_en, 0);

        // both slots every cycle: count 0->2->3->3->3, so in1_ready is 1,1,0,0
        got_pc.delete(); got_bta.delete();
        r1_tab  = 4'b0011;
        next_id = 0;
        for (int c = 0; c < 4; c++) begin
            in0_valid = 1'b1; in0_pc = 32'h100 + 32'(4 * next_id);
            in0_bta = 32'h8000 + 32'(next_id); in0_type = CALL;
            in1_valid = 1'b1; in1_pc = 32'h100 + 32'(4 * (next_id + 1));
            in1_bta = 32'h8000 + 32'(next_id + 1); in1_type = RETURN;
            chk($sformatf("t2_ready0_c%0d", c), in0_ready, 1);
            chk($sformatf("t2_ready1_c%0d", c), in1_ready, r1_tab[c]);
            next_id += 1 + int'(r1_tab[c]);
            tick();
        end
        idle_inputs();
        chk("t2_count_full", dut.fifo_count, 3);
        for (int k = 0; k < 8; k++) tick();
        chk("t2_n_updates", got_pc.size(), 6);
        for (int k = 0; k < 6 && k < got_pc.size(); k++) begin
            chk($sformatf("t2_pc_%0d", k),  got_pc[k],  32'h100 + 32'(4 * k));
            chk($sformatf("t2_bta_%0d", k), got_bta[k], 32'h8000 + 32'(k));
        end
        chk("t2_count_drained", dut.fifo_count, 0);

        // three queued, then flush (plus a same-cycle request): all discarded
        in0_valid = 1'b1; in0_pc = 32'h500; in0_bta = 32'h600;
        in1_valid = 1'b1; in1_pc = 32'h504; in1_bta = 32'h604;
        tick();
        in0_pc = 32'h508; in0_bta = 32'h608;
        in1_pc = 32'h50c; in1_bta = 32'h60c;
        tick();
        chk("t3_count3", dut.fifo_count, 3);
        in1_valid = 1'b0;
        in0_pc = 32'h510; in0_bta = 32'h610;
        flush_req = 1'b1;
        got_pc.delete(); got_bta.delete();
        tick();
        flush_req = 1'b0;
        idle_inputs();
        for (int i = 0; i < SETS; i++) begin
            chk($sformatf("t3_clear_en_%0d", i),  clear_en,   1);
            chk($sformatf("t3_clear_idx_%0d", i), clear_idx,  i);
            chk($sformatf("t3_busy_%0d", i),      flush_busy, 1);
            chk($sformatf("t3_ready0_%0d", i),    in0_ready,  0);
            chk($sformatf("t3_ready1_%0d", i),    in1_ready,  0);
            tick();
        end
        chk("t3_clear_done", clear_en,   0);
        chk("t3_busy_done",  flush_busy, 0);
        chk("t3_count0",     dut.fifo_count, 0);
        chk("t3_ready0",     in0_ready, 1);
        chk("t3_ready1",     in1_ready, 1);
        for (int k = 0; k < 3; k++) tick();
        chk("t3_no_updates", got_pc.size(), 0);

        // restart at clear_idx 10: 11 + 32 = 43 clear cycles
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n_clr     = 0;
        restarted = 1'b0;
        for (int k = 0; k < 120; k++) begin
            if (!clear_en) break;
            n_clr++;
            if ((clear_idx == 10) && !restarted) begin
                flush_req = 1'b1;
                restarted = 1'b1;
                tick();
                flush_req = 1'b0;
                chk("t4_restart_idx", clear_idx, 0);
            end else begin
                tick();
            end
        end
        chk("t4_clear_cycles", n_clr, 43);

        // duplicate pc behind a draining head
        got_pc.delete(); got_bta.delete();
        in0_valid = 1'b1; in0_pc = 32'h10; in0_bta = 32'h11;  in0_type = DIRECT;
        in1_valid = 1'b1; in1_pc = 32'h40; in1_bta = 32'h100; in1_type = INDIRECT;
        tick();
        in1_valid = 1'b0;
        in0_pc = 32'h40; in0_bta = 32'h200; in0_type = INDIRECT;
        tick();
        idle_inputs();
`ifdef BTB_UPD_COALESCE_EN
        chk("t5_count", dut.fifo_count, 1);
`else
        chk("t5_count", dut.fifo_count, 2);
`endif
        for (int k = 0; k < 5; k++) tick();
`ifdef BTB_UPD_COALESCE_EN
        chk("t5_n_updates", got_pc.size(), 2);
        if (got_pc.size() >= 2) begin
            chk("t5_pc0",  got_pc[0],  32'h10);
            chk("t5_pc1",  got_pc[1],  32'h40);
            chk("t5_bta1", got_bta[1], 32'h200);
        end
`else
        chk("t5_n_updates", got_pc.size(), 3);
        if (got_pc.size() >= 3) begin
            chk("t5_pc0",  got_pc[0],  32'h10);
            chk("t5_pc1",  got_pc[1],  32'h40);
            chk("t5_bta1", got_bta[1], 32'h100);
            chk("t5_pc2",  got_pc[2],  32'h40);
            chk("t5_bta2", got_bta[2], 32'h200);
        end
`endif

        // reset in the middle of a sweep
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (clear_idx == 5) break;
            tick();
        end
        chk("t6_reached_idx5", clear_idx, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_clear_en",  clear_en,   0);
        chk("t6_busy",      flush_busy, 0);
        chk("t6_clear_idx", clear_idx,  0);
        chk("t6_count",     dut.fifo_count, 0);
        chk("t6_ready0",    in0_ready,  1);
        chk("t6_ready1",    in1_ready,  1);
        tick();
        chk("t6_stay_idle", clear_en,   0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
